// File: rtl/alu_defs_pkg.sv
// ----------------------------------------------------------------------------
// alu_defs
//   Shared ALU control codes and divider FSM state encoding used by the
//   EX-stage execution units.
//   Contents:
//     NO_OP, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU   5-bit ALUctrl codes
//     div_state_t                                   S_IDLE / S_CALC / S_DONE
//     is_div_op()                                   true for the four RV32M divide codes
// ----------------------------------------------------------------------------
package alu_defs;

    localparam logic [4:0] NO_OP    = 5'h00;
    localparam logic [4:0] ALU_DIV  = 5'h10;
    localparam logic [4:0] ALU_DIVU = 5'h11;
    localparam logic [4:0] ALU_REM  = 5'h12;
    localparam logic [4:0] ALU_REMU = 5'h13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] ctrl);
        return (ctrl == ALU_DIV) || (ctrl == ALU_DIVU) ||
               (ctrl == ALU_REM) || (ctrl == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_div_unit_step.sv
// ----------------------------------------------------------------------------
// ex_div_unit_step (module ex_div_step)
//   One combinational radix-2 restoring division step on unsigned magnitudes.
//   The partial remainder and quotient register form one double-width shift
//   register; each step shifts it left by one, trial-subtracts the divisor
//   from the upper half and records success in the quotient LSB.
//   Ports:
//     rem_i      in   XLEN  current partial remainder
//     quot_i     in   XLEN  current quotient / remaining dividend bits
//     divisor_i  in   XLEN  divisor magnitude
//     rem_o      out  XLEN  partial remainder after this step
//     quot_o     out  XLEN  quotient after this step
// ----------------------------------------------------------------------------
module ex_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The invariant rem < divisor keeps a successful trial below 2^XLEN,
    // so bit XLEN of the difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, quot_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[XLEN]) begin
            rem_o  = trial[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o  = shifted[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// ----------------------------------------------------------------------------
// ex_div_unit
//   EX-stage iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   Accepts an instruction from the ID/EX register, stalls the front end while
//   it iterates (one bit per cycle, XLEN cycles), then emits a one-cycle result
//   pulse towards EX/MEM.
//   Optional feature: define DIV_FAST_PATH_EN to resolve divide-by-zero and the
//   signed overflow case (MIN / -1) directly at accept, skipping iteration.
//   Ports:
//     clk           in   1     clock, rising edge
//     rst           in   1     asynchronous active-high reset
//     valid_i       in   1     ID/EX holds a valid instruction
//     alu_ctrl_i    in   5     ALUctrl code
//     op_a_i        in   XLEN  dividend
//     op_b_i        in   XLEN  divisor
//     reg_waddr_i   in   5     destination register
//     flush_i       in   1     pipeline flush
//     stall_o       out  1     hold ID/EX and upstream stages
//     result_o      out  XLEN  quotient or remainder (holds between results)
//     result_vld_o  out  1     one-cycle pulse, result_o/reg_waddr_o valid
//     reg_waddr_o   out  5     destination register of the completed op
// ----------------------------------------------------------------------------
module ex_div_unit
    import alu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      alu_ctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_vld_o,
    output logic [4:0]      reg_waddr_o
);

    localparam int CNT_W = $clog2(XLEN);

    // Apply RISC-V sign/special-case rules to the unsigned magnitude results.
    function automatic logic [XLEN-1:0] fix_result(
        input logic [XLEN-1:0] quot_mag,
        input logic [XLEN-1:0] rem_mag,
        input logic            want_rem,
        input logic            neg_quot,
        input logic            neg_rem,
        input logic            by_zero
    );
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        q = by_zero ? {XLEN{1'b1}} : (neg_quot ? -quot_mag : quot_mag);
        r = neg_rem ? -rem_mag : rem_mag;
        return want_rem ? r : q;
    endfunction

    div_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN-1:0] rem_q, quot_q, dvsr_q;
    logic            is_rem_q, neg_quot_q, neg_rem_q, div0_q;
    logic [4:0]      waddr_q;

    logic [XLEN-1:0] result_q;
    logic [4:0]      res_waddr_q;

    logic [XLEN-1:0] step_rem, step_quot;

    // Accept-time decode of the ID/EX operands.
    logic            is_div, is_signed, is_rem;
    logic            a_neg, b_neg, div0, fast, accept, last_step;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        is_div    = is_div_op(alu_ctrl_i);
        is_signed = (alu_ctrl_i == ALU_DIV) || (alu_ctrl_i == ALU_REM);
        is_rem    = (alu_ctrl_i == ALU_REM) || (alu_ctrl_i == ALU_REMU);
        a_neg     = is_signed & op_a_i[XLEN-1];
        b_neg     = is_signed & op_b_i[XLEN-1];
        a_mag     = a_neg ? -op_a_i : op_a_i;
        b_mag     = b_neg ? -op_b_i : op_b_i;
        div0      = (op_b_i == '0);
        accept    = (state_q == S_IDLE) & valid_i & is_div & ~flush_i;
        last_step = (cnt_q == CNT_W'(XLEN - 1));
    end

`ifdef DIV_FAST_PATH_EN
    logic ovf;
    always_comb begin
        ovf  = is_signed & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == {XLEN{1'b1}});
        fast = div0 | ovf;
    end
`else
    always_comb fast = 1'b0;
`endif

    ex_div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        result_vld_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    state_d = fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall_o = 1'b1;
                if (flush_i)
                    state_d = S_IDLE;
                else if (last_step)
                    state_d = S_DONE;
            end
            S_DONE: begin
                result_vld_o = ~flush_i;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architecturally visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            res_waddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                if (fast) begin
                    // Fast path: divide-by-zero keeps |a| as remainder, overflow
                    // has quotient magnitude 2^(XLEN-1) and remainder zero.
                    result_q <= fix_result(div0 ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}},
                                           div0 ? a_mag : '0,
                                           is_rem, a_neg ^ b_neg, a_neg, div0);
                    res_waddr_q <= reg_waddr_i;
                end
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + 1'b1;
                if (last_step && !flush_i) begin
                    result_q    <= fix_result(step_quot, step_rem, is_rem_q,
                                              neg_quot_q, neg_rem_q, div0_q);
                    res_waddr_q <= waddr_q;
                end
            end
        end
    end

    // Iteration datapath; its contents are meaningless outside CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q      <= '0;
            quot_q     <= a_mag;
            dvsr_q     <= b_mag;
            is_rem_q   <= is_rem;
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div0_q     <= div0;
            waddr_q    <= reg_waddr_i;
        end else if (state_q == S_CALC) begin
            rem_q  <= step_rem;
            quot_q <= step_quot;
        end
    end

    assign result_o    = result_q;
    assign reg_waddr_o = res_waddr_q;

endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  alu_ctrl_i = NO_OP;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic [31:0] result_o;
    logic        result_vld_o;
    logic [4:0]  reg_waddr_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int vld_cyc = 0;

    ex_div_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .alu_ctrl_i   (alu_ctrl_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .reg_waddr_i  (reg_waddr_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .result_o     (result_o),
        .result_vld_o (result_vld_o),
        .reg_waddr_o  (reg_waddr_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            ALU_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat_left(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
        logic sgn;
        sgn = (c == ALU_DIV) || (c == ALU_REM);
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 0;
`endif
        return 32;
    endfunction

    // Timeline model: after an accept the result appears a fixed number of
    // cycles later unless a flush or reset intervenes.
    logic        mdl_busy = 1'b0;
    int          mdl_left = 0;
    logic [31:0] mdl_res = '0;
    logic [4:0]  mdl_wa = '0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_wa = '0;

    always @(negedge clk) begin
        logic acc;
        logic exp_vld;
        if (rst) begin
            chk("rst_stall", 32'(stall_o), 0);
            chk("rst_vld", 32'(result_vld_o), 0);
            chk("rst_result", result_o, 0);
            chk("rst_waddr", 32'(reg_waddr_o), 0);
            mdl_busy = 1'b0;
            last_res = '0;
            last_wa  = '0;
        end else if (mdl_busy && mdl_left == 0) begin
            exp_vld = !flush_i;
            chk("done_stall", 32'(stall_o), 0);
            chk("done_vld", 32'(result_vld_o), 32'(exp_vld));
            if (exp_vld) begin
                chk("result", result_o, mdl_res);
                chk("waddr", 32'(reg_waddr_o), 32'(mdl_wa));
                vld_cnt++;
                vld_cyc = cyc;
            end
            last_res = mdl_res;
            last_wa  = mdl_wa;
            mdl_busy = 1'b0;
        end else if (mdl_busy) begin
            chk("busy_stall", 32'(stall_o), 1);
            chk("busy_vld", 32'(result_vld_o), 0);
            chk("busy_hold_res", result_o, last_res);
            chk("busy_hold_wa", 32'(reg_waddr_o), 32'(last_wa));
            if (flush_i) mdl_busy = 1'b0;
            else         mdl_left--;
        end else begin
            acc = valid_i && (alu_ctrl_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) && !flush_i;
            chk("idle_stall", 32'(stall_o), 32'(acc));
            chk("idle_vld", 32'(result_vld_o), 0);
            chk("idle_hold_res", result_o, last_res);
            chk("idle_hold_wa", 32'(reg_waddr_o), 32'(last_wa));
            if (acc) begin
                mdl_busy = 1'b1;
                mdl_res  = ref_div(alu_ctrl_i, op_a_i, op_b_i);
                mdl_wa   = reg_waddr_i;
                mdl_left = ref_lat_left(alu_ctrl_i, op_a_i, op_b_i);
            end
        end
    end

    // Behaves like the ID/EX register: holds the instruction while stalled.
    // Entered and left just after a rising edge.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input int flush_at);
        logic s;
        valid_i     = 1'b1;
        alu_ctrl_i  = c;
        op_a_i      = a;
        op_b_i      = b;
        reg_waddr_i = wa;
        for (int k = 0; k < 200; k++) begin
            flush_i = (k == flush_at);
            @(negedge clk);
            s = stall_o;
            @(posedge clk);
            #1;
            if (k == flush_at || !s) begin
                valid_i = 1'b0;
                flush_i = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL op_timeout: stall_o still high after 200 cycles, expected release");
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int start;
        int cnt0;
        int exp_lat;
        logic [4:0] c;

        // Model pins.
        chk("ref_divu_100_7", ref_div(ALU_DIVU, 100, 7), 14);
        chk("ref_remu_100_7", ref_div(ALU_REMU, 100, 7), 2);
        chk("ref_div_m7_2", ref_div(ALU_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
        chk("ref_rem_m7_2", ref_div(ALU_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
        chk("ref_divu_5_0", ref_div(ALU_DIVU, 5, 0), 32'hFFFF_FFFF);
        chk("ref_rem_5_0", ref_div(ALU_REM, 5, 0), 5);
        chk("ref_div_ovf", ref_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("ref_rem_ovf", ref_div(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF), 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        start = cyc;
        run_op(ALU_DIVU, 100, 7, 5'd3, -1);
        chk("divu_latency", 32'(vld_cyc - start), 33);
        chk("divu_result", result_o, 14);
        chk("divu_waddr", 32'(reg_waddr_o), 3);
        run_op(ALU_REMU, 100, 7, 5'd4, -1);
        chk("remu_result", result_o, 2);
        run_op(ALU_DIV, 32'hFFFF_FFF9, 2, 5'd5, -1);
        chk("div_neg_result", result_o, 32'hFFFF_FFFD);
        run_op(ALU_REM, 32'hFFFF_FFF9, 2, 5'd6, -1);
        chk("rem_neg_result", result_o, 32'hFFFF_FFFF);

`ifdef DIV_FAST_PATH_EN
        exp_lat = 1;
`else
        exp_lat = 33;
`endif
        start = cyc;
        run_op(ALU_DIVU, 5, 0, 5'd7, -1);
        chk("div0_latency", 32'(vld_cyc - start), 32'(exp_lat));
        chk("div0_result", result_o, 32'hFFFF_FFFF);
        run_op(ALU_REM, 5, 0, 5'd8, -1);
        chk("rem0_result", result_o, 5);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, -1);
        chk("ovf_div_result", result_o, 32'h8000_0000);
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, -1);
        chk("ovf_rem_result", result_o, 0);

        // Flush in CALC, then a fresh op.
        cnt0 = vld_cnt;
        run_op(ALU_DIVU, 1000, 3, 5'd11, 10);
        chk("flush_no_vld", 32'(vld_cnt - cnt0), 0);
        run_op(ALU_DIVU, 9, 3, 5'd12, -1);
        chk("post_flush_result", result_o, 3);
        chk("post_flush_waddr", 32'(reg_waddr_o), 12);

        // Flush on the accept cycle and in the result cycle.
        cnt0 = vld_cnt;
        run_op(ALU_DIV, 77, 5, 5'd13, 0);
        run_op(ALU_DIVU, 77, 5, 5'd14, exp_lat);
        chk("flush_accept_done_no_vld", 32'(vld_cnt - cnt0), 0);

        // Non-divide codes are ignored.
        run_op(NO_OP, 8, 2, 5'd15, -1);
        run_op(5'h01, 8, 2, 5'd16, -1);

        // Asynchronous reset in the middle of an operation.
        cnt0 = vld_cnt;
        valid_i     = 1'b1;
        alu_ctrl_i  = ALU_DIVU;
        op_a_i      = 32'd12345;
        op_b_i      = 32'd17;
        reg_waddr_i = 5'd17;
        repeat (6) @(posedge clk);
        #1;
        valid_i = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(stall_o), 0);
        chk("async_rst_result", result_o, 0);
        chk("async_rst_waddr", 32'(reg_waddr_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_no_vld", 32'(vld_cnt - cnt0), 0);

        cnt0 = vld_cnt;
        run_op(ALU_DIVU, 50, 5, 5'd20, -1);
        chk("b2b_1_waddr", 32'(reg_waddr_o), 20);
        run_op(ALU_DIVU, 81, 9, 5'd21, -1);
        chk("b2b_2_waddr", 32'(reg_waddr_o), 21);
        chk("b2b_pulses", 32'(vld_cnt - cnt0), 2);

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0:       c = NO_OP;
                1:       c = 5'($urandom);
                default: c = 5'h10 + 5'($urandom_range(0, 3));
            endcase
            run_op(c, pick_val(), pick_val(), 5'($urandom),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 34)) : -1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
